// File: rtl/vec_tx_pkg.sv
// Shared definitions for the vector stream transmitter.
//   tx_state_t  : transmit FSM encoding
//   VEC_WIDTH   : default data word width shared with the layer modules
//   VEC_LEN     : default words per vector shared with the layer modules
//   addr_width  : word-address width for a given vector length (minimum 1)
package vec_tx_pkg;

   localparam int VEC_WIDTH = 16;
   localparam int VEC_LEN   = 64;

   typedef enum logic {TX_IDLE, TX_STREAM} tx_state_t;

   function automatic int addr_width(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/vec_tx_bank.sv
// Ping-pong vector storage: two banks of LEN words of WIDTH bits.
// Ports:
//   clk              : clock
//   wr_en            : write strobe (caller guarantees wr_addr < LEN)
//   wr_bank/wr_addr  : bank and word to write
//   wr_data          : word to store
//   rd_bank/rd_addr  : combinational read address (rd_addr < LEN)
//   rd_data          : word at rd_bank/rd_addr
// Contents are deliberately not reset; only the flags in the top are.
module vec_tx_bank #(
   parameter int WIDTH = 16,
   parameter int LEN   = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_bank,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [2][LEN];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/vec_stream_tx.sv
// Ping-pong vector transmitter feeding the first layer's valid/ready input.
// The host fills one bank through the write port and commits it; committed
// banks are streamed word by word while the host fills the other bank.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : host word write into the current write bank
//   wr_commit         : hand the current write bank to the transmitter
//   wr_ready          : current write bank is free
//   m_data_out_y/m_valid_y/m_ready_y/m_last_y : output stream
//   vec_count         : vectors fully transmitted (wraps)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TX_IDLE   | output invalid, waiting for the read bank to become full
// TX_STREAM | output register holds word idx of the read bank, valid high
module vec_stream_tx
   import vec_tx_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int LEN   = VEC_LEN,
   parameter int AW    = addr_width(LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_commit,
   output logic             wr_ready,
   output logic [WIDTH-1:0] m_data_out_y,
   output logic             m_valid_y,
   input  logic             m_ready_y,
   output logic             m_last_y,
   output logic [15:0]      vec_count
);

   localparam logic [AW-1:0] LAST_IDX = AW'(LEN - 1);

   tx_state_t        state;
   logic [1:0]       full;
   logic             wr_bank;
   logic             rd_bank;
   logic [AW-1:0]    idx;

   logic             bank_we;
   logic             commit_ok;
   logic             rd_sel;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;

   assign wr_ready  = !full[wr_bank];
   assign bank_we   = wr_en && wr_ready && (int'(wr_addr) < LEN);
   assign commit_ok = wr_commit && wr_ready;
   assign m_last_y  = m_valid_y && (idx == LAST_IDX);

   // Read address is the word the output register loads at the next edge:
   // word 0 of the read bank from idle, the next word mid-vector, or word 0
   // of the other bank when chaining straight into the next vector.
   always_comb begin
      rd_sel  = rd_bank;
      rd_addr = '0;
      if (state == TX_STREAM) begin
         if (idx == LAST_IDX) begin
            rd_sel = ~rd_bank;
         end else begin
            rd_addr = idx + 1'b1;
         end
      end
   end

   vec_tx_bank #(
      .WIDTH (WIDTH),
      .LEN   (LEN),
      .AW    (AW)
   ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_bank (rd_sel),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= TX_IDLE;
         full         <= 2'b00;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         idx          <= '0;
         m_data_out_y <= '0;
         m_valid_y    <= 1'b0;
         vec_count    <= 16'd0;
      end else begin
         // A commit only targets a free bank and a release only a full one,
         // so these two updates never hit the same flag.
         if (commit_ok) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
         end

         case (state)
            TX_IDLE: begin
               if (full[rd_bank]) begin
                  m_data_out_y <= rd_data;
                  m_valid_y    <= 1'b1;
                  idx          <= '0;
                  state        <= TX_STREAM;
               end
            end
            TX_STREAM: begin
               if (m_ready_y) begin
                  if (idx != LAST_IDX) begin
                     m_data_out_y <= rd_data;
                     idx          <= idx + 1'b1;
                  end else begin
                     full[rd_bank] <= 1'b0;
                     rd_bank       <= ~rd_bank;
                     vec_count     <= vec_count + 16'd1;
                     // Only a bank already full before this edge chains
                     // without a bubble; a same-edge commit starts from idle.
                     if (full[~rd_bank]) begin
                        m_data_out_y <= rd_data;
                        idx          <= '0;
                     end else begin
                        m_valid_y <= 1'b0;
                        state     <= TX_IDLE;
                     end
                  end
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule
